muldiv_controller: RTL and testbench
====================================

// Module: muldiv_controller
// PURPOSE
//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU, sitting beside the execute-stage ALU.
//  It accepts an operation from execute, runs an iterative shift-add multiply or a restoring divide,
//  and owns the architectural HI/LO registers.
//  It serves MFHI/MFLO reads and raises a pipeline stall while a result is pending.
// PARAMETERS
//  WIDTH      32  operand width; HI/LO are WIDTH bits each
//  CNT_W      6   iteration counter width, >= clog2(WIDTH+1)
// PORTS
//  clock         in   1      single clock; all state on rising edge
//  reset         in   1      asynchronous, active-high
//  start         in   1      execute presents a mul/div op this cycle
//  funct         in   6      R-type funct: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
//  rs_data       in   WIDTH  dividend / multiplicand
//  rt_data       in   WIDTH  divisor / multiplier
//  read_hi       in   1      MFHI in execute
//  read_lo       in   1      MFLO in execute
//  busy          out  1      operation in flight
//  stall         out  1      hold execute and earlier stages
//  done          out  1      one-cycle pulse; HI/LO valid with new result
//  div_by_zero   out  1      pulses with done when divisor was 0
//  hi            out  WIDTH  HI register
//  lo            out  WIDTH  LO register
//  read_data     out  WIDTH  read_hi ? hi : lo (combinational; hi wins if both set)
// BEHAVIOUR
//  Reset values: state=IDLE, hi=lo=0, busy=done=div_by_zero=0. stall follows busy, so it is 0.
//  FSM: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE.
//   IDLE: start=1 with a valid funct latches operands and op. Other functs are ignored.
//   PREP: signed ops take |rs|, |rt| and record signs. Clear accumulator and counter.
//   ITER: one bit per cycle.
//    - mul: add multiplicand if multiplier LSB=1, then shift {acc,mplr} right.
//    - div: shift {rem,quo} left, trial-subtract divisor, set quo bit if no borrow.
//   FIX: negate the product if the signs differ. Quotient sign = s_rs^s_rt; remainder sign = s_rs.
//    Write hi/lo on exit from FIX.
//   DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is not accepted.
//  Latency: start sampled at cycle t; busy=1 for t+1 .. t+WIDTH+2; done=1 at t+WIDTH+3 (35 cycles for WIDTH=32).
//  Mul result: {hi,lo} = full 2*WIDTH product. Div result: lo=quotient, hi=remainder.
//  Divide by zero: no early exit, same latency. Result hi=rs_data, lo=all ones; div_by_zero pulses with done.
//  Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0, no flag.
//  stall = busy & (read_hi | read_lo | start).
//   - A start while busy is ignored; upstream holds it via stall and re-presents it.
//   - read_data during busy is don't-care; it is valid once stall drops.
//  hi/lo change only on FIX exit or reset.
//  Reset mid-operation aborts immediately, returns to IDLE and clears hi/lo.
// STRUCTURE
//  Shared package (mips_pkg): funct codes MULT/MULTU/DIV/DIVU/MFHI/MFLO, the FSM state enum, and WIDTH.
//  One sub-module, muldiv_iter_core: the PREP/ITER/FIX datapath. Its interface is load, op, signed,
//   a step enable, and result hi/lo. This top holds the FSM, counter, HI/LO and stall logic.
// TESTING
//  1 Reset asserted mid-ITER -> busy=0, hi=lo=0 that cycle (async), FSM IDLE; next start runs normally.
//  2 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at t+35, hi=0xFFFFFFFE, lo=0x00000001; MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  3 DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4 DIVU 0x1234/0 -> done at t+35, div_by_zero=1 for one cycle, hi=0x1234, lo=0xFFFFFFFF.
//  5 read_hi=1 at t+5 -> stall=1 through t+WIDTH+2, stall=0 at t+35, read_data=new hi.
//    Second start at t+3 -> ignored, result matches the first op.
//  6 Back-to-back: start held on the cycle after done -> accepted; funct=100000 start -> no busy, hi/lo unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the mul/div sequencer: funct codes, FSM states, datapath width.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiply / restoring divide on magnitudes,
// with the sign fix-up applied combinationally on the result outputs.
module muldiv_iter_core
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic             i_prep,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_dbz
);

    logic [WIDTH-1:0]   r_rs, r_rt;
    logic               r_div, r_sgn;
    logic               r_neg_q, r_neg_r;
    // r_m: multiplicand (mul) or divisor (div); {r_acc,r_q}: product or {rem,quo}
    logic [WIDTH-1:0]   r_m, r_acc, r_q;

    logic               w_sa, w_sb;
    logic [WIDTH-1:0]   w_abs_rs, w_abs_rt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_fits;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_sa     = r_sgn & r_rs[WIDTH-1];
    assign w_sb     = r_sgn & r_rt[WIDTH-1];
    assign w_abs_rs = w_sa ? -r_rs : r_rs;
    assign w_abs_rt = w_sb ? -r_rt : r_rt;

    // Multiply step: conditional add with carry out, then {acc,mplr} >> 1
    assign w_sum    = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_m : '0)};

    // Divide step: {rem,quo} << 1, trial subtract; remainder stays below the divisor
    assign w_rem_sh = {r_acc, r_q[WIDTH-1]};
    assign w_fits   = (w_rem_sh >= {1'b0, r_m});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_m;

    // Operand capture, magnitude prep, then one iteration per enabled cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rs    <= '0;
            r_rt    <= '0;
            r_div   <= 1'b0;
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
        end else if (i_load) begin
            r_rs  <= i_rs;
            r_rt  <= i_rt;
            r_div <= i_div;
            r_sgn <= i_signed;
        end else if (i_prep) begin
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_m     <= r_div ? w_abs_rt : w_abs_rs;
            r_q     <= r_div ? w_abs_rs : w_abs_rt;
            r_acc   <= '0;
        end else if (i_step) begin
            if (r_div) begin
                r_acc <= w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], w_fits};
            end else begin
                r_acc <= w_sum[WIDTH:1];
                r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end
        end
    end

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_q : r_q;
    assign w_rem      = r_neg_r ? -r_acc : r_acc;
    assign o_dbz      = r_div & (r_rt == '0);

    // Result select: signed product, fixed quotient/remainder, or the divide-by-zero pattern
    always_comb begin
        o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        o_lo = w_prod_fix[WIDTH-1:0];
        if (r_div) begin
            if (o_dbz) begin
                o_hi = r_rs;
                o_lo = '1;
            end else begin
                o_hi = w_rem;
                o_lo = w_quo;
            end
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// Mul/div sequencer: FSM, iteration counter, HI/LO ownership and pipeline stall.
module muldiv_controller
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             read_hi,
    input  logic             read_lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] read_data
);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_dbz;

    logic             w_valid_funct, w_accept;
    logic             w_busy, w_done, w_load, w_prep, w_step, w_fix, w_last;
    logic [WIDTH-1:0] w_core_hi, w_core_lo;
    logic             w_core_dbz;

    assign w_valid_funct = (funct == F_MULT) || (funct == F_MULTU) ||
                           (funct == F_DIV)  || (funct == F_DIVU);
    assign w_accept      = (r_state == S_IDLE) && start && w_valid_funct;
    assign w_last        = (r_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and per-state control strobes
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        w_load = 1'b0;
        w_prep = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = w_accept;
                if (w_accept) w_next = S_PREP;
            end
            S_PREP: begin
                w_busy = 1'b1;
                w_prep = 1'b1;
                w_next = S_ITER;
            end
            S_ITER: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (w_last) w_next = S_FIX;
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_fix  = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Iteration counter: cleared in PREP, counts ITER cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       r_cnt <= '0;
        else if (w_prep) r_cnt <= '0;
        else if (w_step) r_cnt <= r_cnt + CNT_W'(1);
    end

    // HI/LO and the divide-by-zero flag are committed only when leaving FIX
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_dbz <= 1'b0;
        end else if (w_fix) begin
            r_hi  <= w_core_hi;
            r_lo  <= w_core_lo;
            r_dbz <= w_core_dbz;
        end
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_div    (funct[1]),
        .i_signed (~funct[0]),
        .i_rs     (rs_data),
        .i_rt     (rt_data),
        .i_prep   (w_prep),
        .i_step   (w_step),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo),
        .o_dbz    (w_core_dbz)
    );

    assign busy        = w_busy;
    assign done        = w_done;
    assign div_by_zero = w_done & r_dbz;
    assign stall       = w_busy & (read_hi | read_lo | start);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign read_data   = read_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller against a plain-arithmetic reference model.
module tb_muldiv_controller;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [5:0]   funct = '0;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic         read_hi = 1'b0;
    logic         read_lo = 1'b0;
    logic         busy, stall, done, div_by_zero;
    logic [W-1:0] hi, lo, read_data;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] e_hi = '0, e_lo = '0, p_hi = '0, p_lo = '0;
    logic         e_dbz = 1'b0;

    muldiv_controller #(.WIDTH(W), .CNT_W(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .funct       (funct),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .read_hi     (read_hi),
        .read_lo     (read_lo),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .read_data   (read_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic: {dbz, hi, lo}
    function automatic logic [2*W:0] model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        model = '0;
        case (f)
            F_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                model = {1'b0, p};
            end
            F_MULT: begin
                p = sa * sb;
                model = {1'b0, p};
            end
            F_DIVU: begin
                if (b == 0) model = {1'b1, a, 32'hFFFF_FFFF};
                else        model = {1'b0, a % b, a / b};
            end
            F_DIV: begin
                if (b == 0) model = {1'b1, a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {1'b0, r[31:0], q[31:0]};
                end
            end
            default: model = '0;
        endcase
    endfunction

    // Present one op for a single cycle; returns in the first cycle after acceptance
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        start = 1'b1; funct = f; rs_data = a; rt_data = b;
        @(negedge clock);
        start = 1'b0; funct = '0; rs_data = $urandom; rt_data = $urandom;
    endtask

    // Walk cycles from t+1 until done (bounded), checking busy/stall/hold and the result
    task automatic wait_done(input int rd_at, input int restart_at);
        int k;
        k = 1;
        #1 chk1("busy_first", busy, 1'b1);
        while (k < 45) begin
            read_hi = (rd_at != 0) && (k >= rd_at);
            if (restart_at != 0 && k == restart_at) begin
                start = 1'b1; funct = F_DIVU; rs_data = 32'h5555; rt_data = 32'h3;
            end else begin
                start = 1'b0; funct = '0;
            end
            #1;
            if (done) break;
            if (rd_at != 0 && k >= rd_at) chk1("stall_read", stall, 1'b1);
            if (restart_at != 0 && k == restart_at) chk1("stall_start", stall, 1'b1);
            if (k == 10) begin
                chk("hi_hold", hi, p_hi);
                chk("lo_hold", lo, p_lo);
            end
            if (k == W + 2) chk1("busy_last", busy, 1'b1);
            @(negedge clock);
            k++;
        end
        chk_int("latency", k, W + 3);
        chk1("busy_at_done", busy, 1'b0);
        chk("hi", hi, e_hi);
        chk("lo", lo, e_lo);
        chk1("div_by_zero", div_by_zero, e_dbz);
        if (rd_at != 0) begin
            chk1("stall_drop", stall, 1'b0);
            chk("read_data_hi", read_data, e_hi);
        end
        read_hi = 1'b0;
        start   = 1'b0;
    endtask

    task automatic pulse_end();
        @(negedge clock);
        #1;
        chk1("done_one_cycle", done, 1'b0);
        chk1("dbz_one_cycle", div_by_zero, 1'b0);
    endtask

    task automatic run(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int rd_at, input int restart_at);
        p_hi = e_hi;
        p_lo = e_lo;
        {e_dbz, e_hi, e_lo} = model(f, a, b);
        issue(f, a, b);
        wait_done(rd_at, restart_at);
        pulse_end();
    endtask

    initial begin
        logic [5:0]   rf;
        logic [W-1:0] ra, rb;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_dbz", div_by_zero, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        reset = 1'b0;

        // Directed multiply / divide cases
        run(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run(F_MULT,  32'hFFFF_FFFD, 32'd7,         0, 0);
        run(F_DIVU,  32'd100,       32'd7,         0, 0);
        run(F_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0);
        run(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run(F_DIVU,  32'h0000_1234, 32'd0,         0, 0);
        run(F_DIV,   32'hFFFF_FFFB, 32'd0,         0, 0);

        // MFHI during busy stalls until the result lands; a start while busy is dropped
        run(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5, 0);
        run(F_DIV,   32'd1000,      32'hFFFF_FFFD, 0, 3);

        // Read mux while idle: hi wins when both are requested
        @(negedge clock);
        read_hi = 1'b1; read_lo = 1'b1;
        #1 chk("read_both", read_data, e_hi);
        chk1("stall_idle", stall, 1'b0);
        read_hi = 1'b0;
        #1 chk("read_lo", read_data, e_lo);
        read_lo = 1'b0;

        // Back-to-back: start asserted through DONE is taken only in the following IDLE cycle
        p_hi = e_hi; p_lo = e_lo;
        {e_dbz, e_hi, e_lo} = model(F_MULT, 32'h0000_0123, 32'hFFFF_FF00);
        issue(F_MULT, 32'h0000_0123, 32'hFFFF_FF00);
        wait_done(0, 0);
        start = 1'b1; funct = F_DIVU; rs_data = 32'd12345; rt_data = 32'd10;
        @(negedge clock);
        #1 chk1("b2b_idle_not_busy", busy, 1'b0);
        @(negedge clock);
        start = 1'b0; funct = '0;
        p_hi = e_hi; p_lo = e_lo;
        {e_dbz, e_hi, e_lo} = model(F_DIVU, 32'd12345, 32'd10);
        wait_done(0, 0);
        pulse_end();

        // Non mul/div funct is ignored
        issue(6'b100000, 32'hDEAD_BEEF, 32'h1);
        #1 chk1("bad_funct_busy", busy, 1'b0);
        repeat (3) @(negedge clock);
        #1;
        chk("bad_funct_hi", hi, e_hi);
        chk("bad_funct_lo", lo, e_lo);
        chk1("bad_funct_done", done, 1'b0);

        // Randomized ops
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0:       rf = F_MULT;
                1:       rf = F_MULTU;
                2:       rf = F_DIV;
                default: rf = F_DIVU;
            endcase
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 20));
                2:       rb = -W'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run(rf, ra, rb, 0, 0);
        end

        // Reset mid-ITER aborts immediately and clears HI/LO
        run(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        issue(F_MULT, $urandom, $urandom);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        @(negedge clock);
        reset = 1'b0;
        e_hi = '0; e_lo = '0; e_dbz = 1'b0;
        #1 chk1("abort_idle", busy, 1'b0);
        run(F_DIVU, 32'd100, 32'd7, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
